// File: rtl/chess_pkg.sv
// Shared piece codes, board type, FSM states and ownership helpers for the
// board state controller.
package chess_pkg;

  typedef enum logic [3:0] {
    W_ROOK   = 4'd0,
    W_KNIGHT = 4'd1,
    W_BISHOP = 4'd2,
    W_QUEEN  = 4'd3,
    W_KING   = 4'd4,
    W_PAWN   = 4'd5,
    B_ROOK   = 4'd6,
    B_KNIGHT = 4'd7,
    B_BISHOP = 4'd8,
    B_QUEEN  = 4'd9,
    B_KING   = 4'd10,
    B_PAWN   = 4'd11,
    EMPTY    = 4'd15
  } piece_t;

  typedef enum logic [1:0] {
    SIDE_W    = 2'd0,
    SIDE_B    = 2'd1,
    SIDE_NONE = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    PICK_SRC = 2'd0,
    PICK_DST = 2'd1,
    COMMIT   = 2'd2,
    OVER     = 2'd3
  } state_t;

  // board[r][c] is a 4-bit piece code
  typedef logic [7:0][7:0][3:0] board_t;

  // Index c holds the white back-rank piece of column c.
  localparam logic [7:0][3:0] BACK_RANK =
    {4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

  function automatic board_t make_init_board(input logic [3:0] empty_code);
    board_t b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        b[r][c] = empty_code;
      end
    end
    for (int c = 0; c < 8; c++) begin
      b[0][c] = BACK_RANK[c];
      b[1][c] = W_PAWN;
      b[6][c] = B_PAWN;
      b[7][c] = BACK_RANK[c] + 4'd6;
    end
    return b;
  endfunction

  localparam board_t INIT_BOARD = make_init_board(EMPTY);

  function automatic owner_t owner_of(input logic [3:0] code);
    owner_t o;
    if (code <= 4'd5) begin
      o = SIDE_W;
    end else if (code <= 4'd11) begin
      o = SIDE_B;
    end else begin
      o = SIDE_NONE;
    end
    return o;
  endfunction

  function automatic owner_t side_owner(input logic side);
    return side ? SIDE_B : SIDE_W;
  endfunction

  function automatic logic is_king(input logic [3:0] code);
    return (code == W_KING) || (code == B_KING);
  endfunction

endpackage

// File: rtl/board_state_ctrl_if.sv
// Key-pulse inputs and board/status outputs of the board state controller.
interface board_state_ctrl_if;
  import chess_pkg::*;

  logic       game_active;
  logic       move_right;
  logic       move_down;
  logic       select;
  logic       cancel;
  board_t     board;
  logic [2:0] cursor_row;
  logic [2:0] cursor_col;
  logic       src_valid;
  logic [2:0] src_row;
  logic [2:0] src_col;
  logic       turn;
  logic       move_done;
  logic       illegal;
  logic       game_over;
  logic       winner;

  modport master (
    output game_active, move_right, move_down, select, cancel,
    input  board, cursor_row, cursor_col, src_valid, src_row, src_col,
    input  turn, move_done, illegal, game_over, winner
  );

  modport slave (
    input  game_active, move_right, move_down, select, cancel,
    output board, cursor_row, cursor_col, src_valid, src_row, src_col,
    output turn, move_done, illegal, game_over, winner
  );

endinterface

// File: rtl/board_state_ctrl_cursor.sv
// Cursor position: independent 3-bit row/column counters that wrap 7 -> 0.
module cursor_ctrl #(
  parameter logic [2:0] INIT_ROW = 3'd7,
  parameter logic [2:0] INIT_COL = 3'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step_row,
  input  logic       step_col,
  output logic [2:0] row,
  output logic [2:0] col
);

  logic [2:0] row_r;
  logic [2:0] col_r;

  // Counter registers; natural 3-bit overflow provides the wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_r <= INIT_ROW;
      col_r <= INIT_COL;
    end else begin
      if (step_row) begin
        row_r <= row_r + 3'd1;
      end
      if (step_col) begin
        col_r <= col_r + 3'd1;
      end
    end
  end

  assign row = row_r;
  assign col = col_r;

endmodule

// File: rtl/board_state_ctrl.sv
// Authoritative chess board: cursor/selection handling, ownership checks,
// move commit with promotion, side-to-move and king-capture tracking.
module board_state_ctrl
  import chess_pkg::*;
#(
  parameter logic [3:0] EMPTY_CODE      = 4'd15,
  parameter logic [2:0] CURSOR_INIT_ROW = 3'd7,
  parameter logic [2:0] CURSOR_INIT_COL = 3'd0
) (
  input logic               clk,
  input logic               reset_n,
  board_state_ctrl_if.slave bus
);

  localparam board_t RESET_BOARD = make_init_board(EMPTY_CODE);

  state_t     state_r, state_n;
  board_t     board_r, board_n;
  logic       turn_r, turn_n;
  logic       src_valid_r, src_valid_n;
  logic [2:0] src_row_r, src_row_n, src_col_r, src_col_n;
  logic [2:0] dst_row_r, dst_row_n, dst_col_r, dst_col_n;
  logic       move_done_r, move_done_n;
  logic       illegal_r, illegal_n;
  logic       game_over_r, game_over_n;
  logic       winner_r, winner_n;

  logic [2:0] cursor_row_s, cursor_col_s;
  logic       sel_s, cancel_s, cur_owned_s, cur_is_src_s;
  logic [3:0] cur_piece_s, src_piece_s, dst_piece_s, moved_piece_s;

  // cancel outranks select; both are dead while the game screen is inactive
  assign cancel_s = bus.game_active & bus.cancel;
  assign sel_s    = bus.game_active & bus.select & ~bus.cancel;

  cursor_ctrl #(
    .INIT_ROW (CURSOR_INIT_ROW),
    .INIT_COL (CURSOR_INIT_COL)
  ) u_cursor (
    .clk      (clk),
    .reset_n  (reset_n),
    .step_row (bus.game_active & bus.move_down),
    .step_col (bus.game_active & bus.move_right),
    .row      (cursor_row_s),
    .col      (cursor_col_s)
  );

  assign cur_piece_s  = board_r[cursor_row_s][cursor_col_s];
  assign src_piece_s  = board_r[src_row_r][src_col_r];
  assign dst_piece_s  = board_r[dst_row_r][dst_col_r];
  assign cur_owned_s  = (owner_of(cur_piece_s) == side_owner(turn_r));
  assign cur_is_src_s = (cursor_row_s == src_row_r) && (cursor_col_s == src_col_r);

  // Pawn promotion on reaching the far rank.
  always_comb begin
    moved_piece_s = src_piece_s;
    if ((src_piece_s == W_PAWN) && (dst_row_r == 3'd7)) begin
      moved_piece_s = W_QUEEN;
    end else if ((src_piece_s == B_PAWN) && (dst_row_r == 3'd0)) begin
      moved_piece_s = B_QUEEN;
    end else begin
      moved_piece_s = src_piece_s;
    end
  end

  // Next-state and next-output logic of the selection/commit FSM.
  always_comb begin
    state_n     = state_r;
    board_n     = board_r;
    turn_n      = turn_r;
    src_valid_n = src_valid_r;
    src_row_n   = src_row_r;
    src_col_n   = src_col_r;
    dst_row_n   = dst_row_r;
    dst_col_n   = dst_col_r;
    move_done_n = 1'b0;
    illegal_n   = 1'b0;
    game_over_n = game_over_r;
    winner_n    = winner_r;
    case (state_r)
      PICK_SRC: begin
        if (sel_s) begin
          if (cur_owned_s) begin
            src_row_n   = cursor_row_s;
            src_col_n   = cursor_col_s;
            src_valid_n = 1'b1;
            state_n     = PICK_DST;
          end else begin
            illegal_n = 1'b1;
          end
        end else begin
          state_n = PICK_SRC;
        end
      end
      PICK_DST: begin
        if (!bus.game_active || cancel_s || (sel_s && cur_is_src_s)) begin
          src_valid_n = 1'b0;
          state_n     = PICK_SRC;
        end else if (sel_s && cur_owned_s) begin
          src_row_n = cursor_row_s;
          src_col_n = cursor_col_s;
        end else if (sel_s) begin
          dst_row_n = cursor_row_s;
          dst_col_n = cursor_col_s;
          state_n   = COMMIT;
        end else begin
          state_n = PICK_DST;
        end
      end
      COMMIT: begin
        board_n[src_row_r][src_col_r] = EMPTY_CODE;
        board_n[dst_row_r][dst_col_r] = moved_piece_s;
        src_valid_n = 1'b0;
        move_done_n = 1'b1;
        if (is_king(dst_piece_s)) begin
          game_over_n = 1'b1;
          winner_n    = turn_r;
          state_n     = OVER;
        end else begin
          turn_n  = ~turn_r;
          state_n = PICK_SRC;
        end
      end
      OVER: begin
        state_n = OVER;
      end
      default: begin
        state_n = PICK_SRC;
      end
    endcase
  end

  // State and output registers; reset restores the full starting position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= PICK_SRC;
      board_r     <= RESET_BOARD;
      turn_r      <= 1'b1;
      src_valid_r <= 1'b0;
      src_row_r   <= 3'd0;
      src_col_r   <= 3'd0;
      dst_row_r   <= 3'd0;
      dst_col_r   <= 3'd0;
      move_done_r <= 1'b0;
      illegal_r   <= 1'b0;
      game_over_r <= 1'b0;
      winner_r    <= 1'b0;
    end else begin
      state_r     <= state_n;
      board_r     <= board_n;
      turn_r      <= turn_n;
      src_valid_r <= src_valid_n;
      src_row_r   <= src_row_n;
      src_col_r   <= src_col_n;
      dst_row_r   <= dst_row_n;
      dst_col_r   <= dst_col_n;
      move_done_r <= move_done_n;
      illegal_r   <= illegal_n;
      game_over_r <= game_over_n;
      winner_r    <= winner_n;
    end
  end

  assign bus.board      = board_r;
  assign bus.cursor_row = cursor_row_s;
  assign bus.cursor_col = cursor_col_s;
  assign bus.src_valid  = src_valid_r;
  assign bus.src_row    = src_row_r;
  assign bus.src_col    = src_col_r;
  assign bus.turn       = turn_r;
  assign bus.move_done  = move_done_r;
  assign bus.illegal    = illegal_r;
  assign bus.game_over  = game_over_r;
  assign bus.winner     = winner_r;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Self-checking bench: directed scenarios plus random key traffic, all
// checked against a move-level reference model of the chess board.
module tb_board_state_ctrl;
  import chess_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  board_state_ctrl_if bus();

  board_state_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  int mb[8][8];
  int mcr, mcc, mturn, mvalid, msr, msc, mover, mwin;
  int back[8] = '{0, 1, 2, 3, 4, 2, 1, 0};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int side_of(input int code);
    if (code >= 0 && code <= 5) return 0;
    if (code >= 6 && code <= 11) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mb[r][c] = 15;
    for (int c = 0; c < 8; c++) begin
      mb[0][c] = back[c];
      mb[1][c] = 5;
      mb[6][c] = 11;
      mb[7][c] = back[c] + 6;
    end
    mcr = 7; mcc = 0; mturn = 1; mvalid = 0; msr = 0; msc = 0; mover = 0; mwin = 0;
  endtask

  function automatic board_t mpack();
    board_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = 4'(mb[r][c]);
    return b;
  endfunction

  task automatic check_all(input string tag, input bit exp_md, input bit exp_ill);
    chk({tag, ".cursor_row"}, bus.cursor_row, mcr);
    chk({tag, ".cursor_col"}, bus.cursor_col, mcc);
    chk({tag, ".src_valid"}, bus.src_valid, mvalid);
    if (mvalid != 0) begin
      chk({tag, ".src_row"}, bus.src_row, msr);
      chk({tag, ".src_col"}, bus.src_col, msc);
    end
    chk({tag, ".turn"}, bus.turn, mturn);
    chk({tag, ".game_over"}, bus.game_over, mover);
    if (mover != 0) chk({tag, ".winner"}, bus.winner, mwin);
    chk({tag, ".move_done"}, bus.move_done, exp_md);
    chk({tag, ".illegal"}, bus.illegal, exp_ill);
    chk({tag, ".board"}, bus.board, mpack());
  endtask

  // One clock of key inputs; a committing select is followed by an idle commit cycle.
  task automatic cycle(input bit ga, input bit mr, input bit md, input bit sel, input bit can);
    bit exp_ill = 1'b0;
    bit commit = 1'b0;
    int dr = 0, dc = 0, own, piece, old;
    @(negedge clk);
    bus.game_active = ga; bus.move_right = mr; bus.move_down = md;
    bus.select = sel; bus.cancel = can;
    if (mover == 0) begin
      if (ga == 0 || can == 1) begin
        mvalid = 0;
      end else if (sel) begin
        own = side_of(mb[mcr][mcc]);
        if (mvalid == 0) begin
          if (own == mturn) begin msr = mcr; msc = mcc; mvalid = 1; end
          else exp_ill = 1'b1;
        end else if (mcr == msr && mcc == msc) begin
          mvalid = 0;
        end else if (own == mturn) begin
          msr = mcr; msc = mcc;
        end else begin
          commit = 1'b1; dr = mcr; dc = mcc;
        end
      end
    end
    if (ga) begin
      if (mr) mcc = (mcc + 1) % 8;
      if (md) mcr = (mcr + 1) % 8;
    end
    @(posedge clk); #1;
    bus.game_active = 1'b1; bus.move_right = 1'b0; bus.move_down = 1'b0;
    bus.select = 1'b0; bus.cancel = 1'b0;
    check_all("step", 1'b0, exp_ill);
    if (commit) begin
      piece = mb[msr][msc]; old = mb[dr][dc];
      if (piece == 5 && dr == 7) piece = 3;
      else if (piece == 11 && dr == 0) piece = 9;
      mb[dr][dc] = piece; mb[msr][msc] = 15; mvalid = 0;
      if (old == 4 || old == 10) begin mover = 1; mwin = mturn; end
      else mturn = 1 - mturn;
      @(posedge clk); #1;
      check_all("commit", 1'b1, 1'b0);
    end
  endtask

  task automatic goto(input int r, input int c);
    while (mcr != r) cycle(1, 0, 1, 0, 0);
    while (mcc != c) cycle(1, 1, 0, 0, 0);
  endtask

  task automatic press_sel();
    cycle(1, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    check_all("reset", 1'b0, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_col;
    reset_n = 1'b0;
    bus.game_active = 1'b1; bus.move_right = 1'b0; bus.move_down = 1'b0;
    bus.select = 1'b0; bus.cancel = 1'b0;
    do_reset();
    chk("init_r0", bus.board[0], {4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0});
    chk("init_r7", bus.board[7], {4'd6, 4'd7, 4'd8, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6});
    chk("init_r3", bus.board[3], 32'hFFFF_FFFF);
    chk("init_cursor", {bus.cursor_row, bus.cursor_col}, 6'o70);

    // wrong side
    goto(1, 0); press_sel();
    chk("wrong_side_ill", bus.illegal, 1'b1);
    chk("wrong_side_src", bus.src_valid, 1'b0);

    // basic move
    goto(6, 4); press_sel();
    goto(4, 4); press_sel();
    chk("move_src_empty", bus.board[6][4], 4'd15);
    chk("move_dst", bus.board[4][4], 4'd11);
    chk("move_done_hi", bus.move_done, 1'b1);
    chk("move_turn", bus.turn, 1'b0);
    cycle(1, 0, 0, 0, 0);
    chk("move_done_lo", bus.move_done, 1'b0);

    // reselect, deselect, cancel priority, game_active drop
    do_reset();
    goto(6, 0); press_sel();
    goto(6, 1); press_sel();
    chk("resel_col", bus.src_col, 3'd1);
    chk("resel_valid", bus.src_valid, 1'b1);
    press_sel();
    chk("desel_valid", bus.src_valid, 1'b0);
    cycle(1, 0, 0, 1, 1);
    chk("cancel_pick_src", bus.src_valid, 1'b0);
    press_sel();
    goto(5, 1);
    cycle(1, 0, 0, 1, 1);
    chk("cancel_pick_dst", bus.src_valid, 1'b0);
    cycle(1, 0, 0, 0, 0);
    chk("cancel_no_move", bus.move_done, 1'b0);
    goto(6, 2); press_sel();
    cycle(0, 0, 0, 1, 0);
    chk("inactive_drop", bus.src_valid, 1'b0);

    // king capture
    do_reset();
    goto(7, 3); press_sel();
    goto(0, 4); press_sel();
    chk("king_over", bus.game_over, 1'b1);
    chk("king_winner", bus.winner, 1'b1);
    chk("king_turn", bus.turn, 1'b1);
    chk("king_sq", bus.board[0][4], 4'd9);
    goto(6, 0); press_sel();
    chk("over_ignored", bus.src_valid, 1'b0);
    cycle(1, 1, 1, 0, 0);
    chk("over_cursor", {bus.cursor_row, bus.cursor_col}, 6'o71);

    // promotion and column wrap
    do_reset();
    goto(6, 0); press_sel(); goto(5, 0); press_sel();
    goto(1, 0); press_sel(); goto(7, 0); press_sel();
    chk("promote_w", bus.board[7][0], 4'd3);
    start_col = mcc;
    repeat (8) cycle(1, 1, 0, 0, 0);
    chk("wrap_col", bus.cursor_col, 3'(start_col));

    // reset while in the commit cycle
    do_reset();
    goto(6, 3); press_sel(); goto(5, 3);
    @(negedge clk); bus.select = 1'b1;
    @(posedge clk); #1; bus.select = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    model_reset();
    chk("rst_commit_board", bus.board, mpack());
    chk("rst_commit_md", bus.move_done, 1'b0);
    chk("rst_commit_turn", bus.turn, 1'b1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (mover != 0 && $urandom_range(0, 7) == 0) do_reset();
      cycle($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_state_ctrl.md
Name: board_state_ctrl

Overview:
- Owns the authoritative 8x8 chess board array and drives it into the screen generator's board input, replacing the static initial board at top level.
- Consumes single-cycle key pulses (from keypress instances) to move a cursor, select a source square, select a destination square and commit moves.
- Enforces ownership rules only: the right side moves, and a player may not capture their own piece. Piece-movement legality is out of scope.
- Tracks side to move, pawn promotion and king capture (game over).

Parameters:
- EMPTY_CODE, 15, piece code for an empty square.
- CURSOR_INIT_ROW, 7, cursor row after reset.
- CURSOR_INIT_COL, 0, cursor column after reset.

Ports:
- clk  in  1  system clock (the VGA clock domain, same as screen_fsm).
- reset_n  in  1  synchronous, active-low reset.
- game_active  in  1  high while screen_fsm is in the game screen; all key pulses are ignored when low.
- move_right  in  1  one-cycle pulse: cursor column +1.
- move_down  in  1  one-cycle pulse: cursor row +1.
- select  in  1  one-cycle pulse: select or commit at the cursor.
- cancel  in  1  one-cycle pulse: drop the current source selection.
- board  out  4x[8][8]  board array; board[r][c] holds the piece code.
- cursor_row, cursor_col  out  3 each  cursor position.
- src_valid  out  1  high while a source square is held.
- src_row, src_col  out  3 each  held source square.
- turn  out  1  side to move: 0 = codes 0..5, 1 = codes 6..11.
- move_done  out  1  one-cycle pulse on commit.
- illegal  out  1  one-cycle pulse on a rejected select.
- game_over  out  1  sticky; set when a king is captured.
- winner  out  1  side that captured the king; valid when game_over is high.

Behaviour:
- Clock and reset: single clock. All registers use a synchronous, active-low reset.
- Reset values:
  - board row 0 = {0,1,2,3,4,2,1,0}
  - board row 1 = all 5
  - board rows 2..5 = all EMPTY_CODE
  - board row 6 = all 11
  - board row 7 = {6,7,8,9,10,8,7,6}
  - cursor = (7,0); turn = 1; src_valid = 0; src = (0,0)
  - move_done = 0, illegal = 0, game_over = 0, winner = 0; state = PICK_SRC
- Ownership: code 0..5 belongs to side 0; code 6..11 belongs to side 1; EMPTY_CODE and codes 12..14 belong to no side.
- Cursor:
  - move_right increments col, move_down increments row; both wrap 7 -> 0 (3-bit modulo).
  - Both pulses in the same cycle apply both increments.
  - The cursor also moves during game_over.
  - Cursor moves apply in any FSM state and are not affected by select or cancel in the same cycle.
- Among select and cancel, cancel takes priority: if both arrive in the same cycle, only cancel takes effect.
- FSM states: PICK_SRC, PICK_DST, COMMIT, OVER.
- PICK_SRC, on select:
  - Cursor square owned by turn: latch src = cursor, src_valid = 1, go to PICK_DST.
  - Otherwise: pulse illegal for 1 cycle and stay.
- PICK_DST:
  - cancel, or select on the src square itself: src_valid = 0, go to PICK_SRC.
  - select on another square owned by turn: src moves to the cursor; stay in PICK_DST; no illegal pulse.
  - select on an empty square or an opponent's square: latch dst = cursor, go to COMMIT.
- COMMIT (exactly 1 cycle; key pulses ignored):
  - board[dst] = board[src], board[src] = EMPTY_CODE.
  - Promotion: a pawn (5) landing on row 7 becomes 3; a pawn (11) landing on row 0 becomes 9.
  - If the old board[dst] was a king (4 or 10): game_over = 1, winner = turn, next state OVER.
  - Otherwise: turn toggles, next state PICK_SRC.
  - In both cases: src_valid = 0, move_done pulses in the same cycle that the board updates.
- Latency: board changes on the second clock edge after the committing select pulse is sampled.
- OVER: select and cancel are ignored; the board is frozen. Only reset exits this state.
- game_active low: select and cancel are ignored. If low while in PICK_DST, drop src_valid and return to PICK_SRC. A COMMIT already in progress completes.
- Reset asserted mid-operation, including in COMMIT: the full initial board is restored on that edge; no partial move survives.
- board is a registered output with no combinational path from the inputs.

Decomposition:
- chess_pkg:
  - piece_t codes (W_ROOK..W_PAWN = 0..5, B_ROOK..B_PAWN = 6..11, EMPTY = 15)
  - INIT_BOARD constant
  - state enum
  - owner_of() function
  - is_king() function
- Sub-module cursor_ctrl: 3-bit row/col wrap counters with the enable and reset logic. The rest stays in board_state_ctrl.

Test Plan:
- Reset: board equals INIT_BOARD, cursor = (7,0), turn = 1, game_over = 0.
- Move: cursor to (6,4), select, move_down x6 and move_right x0 to reach (4,4), select. Expect board[6][4] = 15, board[4][4] = 11, move_done pulses for 1 cycle, turn = 0.
- Wrong side: turn = 1, select on (1,0). Expect illegal pulse, src_valid = 0, board unchanged.
- Deselect and reselect:
  - select (6,0), then select (6,1): src moves to (6,1).
  - select (6,1) again: src_valid = 0, state PICK_SRC.
  - select and cancel in the same cycle: cancel wins.
- Capture of king: preload a position, move piece 9 onto the 4 at (0,4). Expect game_over = 1, winner = 1, turn unchanged, later selects ignored, cursor still moves.
- Promotion and wrap:
  - Side-0 pawn 5 moved to row 7: square becomes 3.
  - move_right x8 returns cursor col to its start value.
  - Reset during COMMIT restores INIT_BOARD.
